// File: rtl/unstrip_scheduler.sv
// Merges two striped byte lanes back into one stream, strictly alternating lane 0 / lane 1.
// Per-lane FIFOs absorb lane skew; an overflow flushes everything and locks the block in ERR until reset.
module unstrip_scheduler #(
   parameter int DEPTH = 4,
   parameter int DW    = 8
) (
   input  logic          clk_2f,
   input  logic          rst,
   input  logic          valid_stripe_0,
   input  logic [DW-1:0] data_stripe_0,
   input  logic          valid_stripe_1,
   input  logic [DW-1:0] data_stripe_1,
   input  logic          pop_en,
   output logic [DW-1:0] data_demux,
   output logic          valid_demux,
   output logic          lane_sel,
   output logic          empty_0,
   output logic          empty_1,
   output logic          full_0,
   output logic          full_1,
   output logic          overflow,
   output logic [1:0]    state
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, ERR = 2'b10} state_t;

   state_t        st, st_next;
   logic [DW-1:0] mem [2][DEPTH];
   logic [DW-1:0] din [2];
   logic [AW-1:0] wr_ptr [2];
   logic [AW-1:0] rd_ptr [2];
   logic [AW:0]   count [2];
   logic [1:0]    push, pop, ovf_lane, nonempty, is_full;
   logic          issue, ovf;

   // Issue only from the current head; a byte pushed this cycle into an empty FIFO is not poppable yet.
   always_comb begin
      din[0]   = data_stripe_0;
      din[1]   = data_stripe_1;
      push     = {valid_stripe_1, valid_stripe_0} & {2{st != ERR}};
      nonempty = {count[1] != '0, count[0] != '0};
      is_full  = {count[1] == (AW+1)'(DEPTH), count[0] == (AW+1)'(DEPTH)};
      issue    = (st == RUN) && pop_en && nonempty[lane_sel];
      pop      = '0;
      if (issue) pop[lane_sel] = 1'b1;
      for (int i = 0; i < 2; i++) begin
         ovf_lane[i] = push[i] && is_full[i] && !pop[i];
      end
      ovf = |ovf_lane;
   end

   always_comb begin
      st_next = st;
      case (st)
         IDLE: if (nonempty[0]) st_next = RUN;
         RUN:  if (nonempty == 2'b00 && !lane_sel && push == 2'b00) st_next = IDLE;
         ERR:  st_next = ERR;
         default: st_next = IDLE;
      endcase
      if (ovf) st_next = ERR;
   end

   always_ff @(posedge clk_2f or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
         data_demux  <= '0;
         valid_demux <= 1'b0;
         lane_sel    <= 1'b0;
         overflow    <= 1'b0;
         st          <= IDLE;
      end else begin
         st <= st_next;
         if (ovf || st == ERR) begin
            // Flush both lanes; the offending byte is dropped.
            for (int i = 0; i < 2; i++) begin
               wr_ptr[i] <= '0;
               rd_ptr[i] <= '0;
               count[i]  <= '0;
            end
            valid_demux <= 1'b0;
            lane_sel    <= 1'b0;
            overflow    <= 1'b1;
         end else begin
            for (int i = 0; i < 2; i++) begin
               if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
               if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
               count[i] <= count[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
            end
            valid_demux <= issue;
            if (issue) begin
               data_demux <= mem[lane_sel][rd_ptr[lane_sel]];
               lane_sel   <= ~lane_sel;
            end else if (st != RUN) begin
               lane_sel <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk_2f) begin
      for (int i = 0; i < 2; i++) begin
         if (push[i] && !ovf) mem[i][wr_ptr[i]] <= din[i];
      end
   end

   assign empty_0 = !nonempty[0];
   assign empty_1 = !nonempty[1];
   assign full_0  = is_full[0];
   assign full_1  = is_full[1];
   assign state   = st;

endmodule

// File: tb/tb_unstrip_scheduler.sv
// Scoreboard bench for unstrip_scheduler: a queue-level reference model predicts issued bytes,
// a negedge monitor pops and compares whenever valid_demux is high, and checks flags every cycle.
module tb_unstrip_scheduler;
   localparam int DEPTH = 4;
   localparam int DW    = 8;

   logic          clk_2f = 1'b0;
   logic          rst    = 1'b1;
   logic          v0 = 1'b0, v1 = 1'b0, pop_en = 1'b0;
   logic [DW-1:0] d0 = '0, d1 = '0;
   logic [DW-1:0] data_demux;
   logic          valid_demux, lane_sel, empty_0, empty_1, full_0, full_1, overflow;
   logic [1:0]    state;

   unstrip_scheduler #(.DEPTH(DEPTH), .DW(DW)) dut (
      .clk_2f(clk_2f), .rst(rst),
      .valid_stripe_0(v0), .data_stripe_0(d0),
      .valid_stripe_1(v1), .data_stripe_1(d1),
      .pop_en(pop_en),
      .data_demux(data_demux), .valid_demux(valid_demux), .lane_sel(lane_sel),
      .empty_0(empty_0), .empty_1(empty_1), .full_0(full_0), .full_1(full_1),
      .overflow(overflow), .state(state)
   );

   // ---------------- clock ----------------
   always #5 clk_2f = ~clk_2f;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Lanes are plain queues; mode 0=idle, 1=run, 2=error.
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] q0 [$];
   logic [DW-1:0] q1 [$];
   int  mode      = 0;
   bit  sel       = 1'b0;
   bit  exp_valid = 1'b0;
   bit  exp_ovf   = 1'b0;
   bit  m_can, m_o0, m_o1, m_go_run, m_go_idle;

   always @(posedge clk_2f or posedge rst) begin
      if (rst) begin
         q0.delete(); q1.delete(); exp_q.delete();
         mode = 0; sel = 1'b0; exp_valid = 1'b0; exp_ovf = 1'b0;
      end else if (mode == 2) begin
         exp_valid = 1'b0;
      end else begin
         m_can = (mode == 1) && pop_en && (sel ? q1.size() != 0 : q0.size() != 0);
         m_o0  = v0 && q0.size() == DEPTH && !(m_can && !sel);
         m_o1  = v1 && q1.size() == DEPTH && !(m_can && sel);
         if (m_o0 || m_o1) begin
            q0.delete(); q1.delete();
            mode = 2; exp_ovf = 1'b1; exp_valid = 1'b0; sel = 1'b0;
         end else begin
            m_go_run  = (mode == 0) && q0.size() != 0;
            m_go_idle = (mode == 1) && q0.size() == 0 && q1.size() == 0 && !sel && !v0 && !v1;
            exp_valid = m_can;
            if (m_can) begin
               if (sel) exp_q.push_back(q1.pop_front());
               else     exp_q.push_back(q0.pop_front());
               sel = !sel;
            end
            if (v0) q0.push_back(d0);
            if (v1) q1.push_back(d1);
            if (m_go_run) mode = 1;
            else if (m_go_idle) mode = 0;
         end
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk_2f) begin
      if (!rst) begin
         check("valid_demux", valid_demux, exp_valid);
         check("lane_sel", lane_sel, sel);
         check("state", state, mode[1:0]);
         check("overflow", overflow, exp_ovf);
         check("empty_0", empty_0, q0.size() == 0);
         check("empty_1", empty_1, q1.size() == 0);
         check("full_0", full_0, q0.size() == DEPTH);
         check("full_1", full_1, q1.size() == DEPTH);
         if (valid_demux) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL data_demux: got %0h, expected no output (t=%0t)", data_demux, $time);
            end else begin
               check("data_demux", data_demux, exp_q.pop_front());
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input bit a0, input logic [DW-1:0] b0,
                       input bit a1, input logic [DW-1:0] b1, input bit pe);
      v0 = a0; d0 = b0; v1 = a1; d1 = b1; pop_en = pe;
      @(posedge clk_2f);
      #1;
   endtask

   task automatic idle(input int n, input bit pe);
      repeat (n) step(1'b0, '0, 1'b0, '0, pe);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_valid"}, valid_demux, 1'b0);
      check({tag, "_data"}, data_demux, '0);
      check({tag, "_lane_sel"}, lane_sel, 1'b0);
      check({tag, "_overflow"}, overflow, 1'b0);
      check({tag, "_empty"}, {empty_1, empty_0}, 2'b11);
      check({tag, "_full"}, {full_1, full_0}, 2'b00);
      check({tag, "_state"}, state, 2'b00);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit a0, a1;
      #3;
      check_reset_values("por");
      #19 rst = 1'b0;
      @(posedge clk_2f);
      #1;

      // Balanced stream
      step(1'b1, 8'h10, 1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1, 8'h20, 1'b1);
      step(1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1, 8'h21, 1'b1);
      idle(8, 1'b1);
      check("balanced_back_to_idle", state, 2'b00);

      // Lane skew: lane 1 first
      step(1'b0, 8'h00, 1'b1, 8'hA0, 1'b1);
      step(1'b0, 8'h00, 1'b1, 8'hA1, 1'b1);
      step(1'b0, 8'h00, 1'b1, 8'hA2, 1'b1);
      step(1'b1, 8'hB0, 1'b0, 8'h00, 1'b1);
      step(1'b1, 8'hB1, 1'b0, 8'h00, 1'b1);
      step(1'b1, 8'hB2, 1'b0, 8'h00, 1'b1);
      idle(10, 1'b1);

      // Back-pressure, then pop+push on a full lane
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, 8'(8'hC0 + i), 1'b1, 8'(8'hD0 + i), 1'b0);
      end
      check("bp_full", {full_1, full_0}, 2'b11);
      check("bp_no_valid", valid_demux, 1'b0);
      step(1'b1, 8'hC4, 1'b0, 8'h00, 1'b1);
      check("bp_no_overflow", overflow, 1'b0);
      check("bp_full0_kept", full_0, 1'b1);
      idle(14, 1'b1);

      // Randomized traffic without overflow
      for (int i = 0; i < 400; i++) begin
         a0 = ($urandom_range(0, 99) < 45) && (q0.size() < DEPTH);
         a1 = ($urandom_range(0, 99) < 45) && (q1.size() < DEPTH);
         step(a0, 8'($urandom), a1, 8'($urandom), $urandom_range(0, 3) != 0);
      end
      idle(14, 1'b1);
      check("random_drained", exp_q.size(), 0);

      // Reset mid-stream with two bytes per lane buffered
      step(1'b1, 8'h31, 1'b1, 8'h41, 1'b0);
      step(1'b1, 8'h32, 1'b1, 8'h42, 1'b0);
      #1 rst = 1'b1;
      #1 check_reset_values("midrst");
      #4 rst = 1'b0;
      step(1'b1, 8'h55, 1'b0, 8'h00, 1'b1);
      idle(1, 1'b1);
      check("rst_55_not_yet", valid_demux, 1'b0);
      idle(1, 1'b1);
      check("rst_55_valid", valid_demux, 1'b1);
      check("rst_55_data", data_demux, 8'h55);
      check("rst_55_lane_sel", lane_sel, 1'b1);
      idle(2, 1'b1);

      // Overflow: five pushes into lane 0 while stalled
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hE0 + i), 1'b0, 8'h00, 1'b0);
      check("ovf_not_yet", overflow, 1'b0);
      step(1'b1, 8'hE4, 1'b0, 8'h00, 1'b0);
      check("ovf_flag", overflow, 1'b1);
      check("ovf_state", state, 2'b10);
      check("ovf_flushed", {empty_1, empty_0}, 2'b11);
      for (int i = 0; i < 8; i++) begin
         step($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1, 8'($urandom), 1'b1);
      end
      check("err_sticky", state, 2'b10);
      check("err_no_valid", valid_demux, 1'b0);

      // Only reset leaves ERR
      #1 rst = 1'b1;
      #1 check_reset_values("errrst");
      #2 rst = 1'b0;
      idle(2, 1'b1);
      check("final_queue_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
